// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one single-ported memory between the IF and DM pipeline stages.
// Optional macro MEM_ARB_STARVE_GUARD_EN bounds how many DM grants may pass a waiting IF.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              pipe_stall
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             owner_dm;
    logic             grant;
    logic             grant_dm;
    logic             starve;

    if (MEM_LAT < 1 || STARVE_MAX < 1) begin : g_param_check
        $error("mem_port_arbiter: MEM_LAT and STARVE_MAX must be >= 1");
    end

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_cnt;

    // Counts DM grants that overtook a waiting fetch; saturates at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (!grant_dm) begin
                starve_cnt <= '0;
            end else if (if_req && starve_cnt != SW'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

    assign starve = if_req && (starve_cnt == SW'(STARVE_MAX));
`else
    assign starve = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant) state_nx = BUSY;
            BUSY:    if (cnt == '0) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        grant      = (state == IDLE) && (if_req || dm_req);
        grant_dm   = dm_req && !starve;
        pipe_stall = (if_req && !if_ack) || (dm_req && !dm_ack);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_dm  <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner_dm <= grant_dm;
                        busy     <= 1'b1;
                        mem_en   <= 1'b1;
                        cnt      <= CNT_W'(MEM_LAT - 1);
                        if (grant_dm) begin
                            mem_we    <= dm_we;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                        end else begin
                            mem_we   <= 1'b0;
                            mem_addr <= if_addr;
                        end
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (owner_dm) begin
                            dm_ack <= 1'b1;
                            // Stores leave the previous load data in place.
                            if (!mem_we) dm_rdata <= mem_rdata;
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
                end
                RESP: begin
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
